branch_predictor: RTL

- Dynamic branch predictor for the pipelined RV32I core.
- Sits directly upstream of fetch's next-PC mux. The `bp_enable` pin the core exposes to its testbenches gates this block.
- Looks up a direct-mapped, tagged table of 2-bit saturating counters with the fetch PC and returns a taken/not-taken guess in the same cycle.
- Trains from resolved branches in execute and keeps branch/mispredict statistics that the CSR/MMIO stats path reads.

---
 rtl/bp_pkg.sv | 13 +
 rtl/bp_cache.sv | 39 +++
 rtl/branch_predictor.sv | 54 +++++
 3 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings and sizing helpers for the branch predictor
package bp_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int pc_w, input int lines);
    return pc_w - $clog2(lines) - 2;
  endfunction
  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    return taken ? ((c == ST) ? ST : ctr_t'(c + 2'd1)) : ((c == SNT) ? SNT : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/bp_cache.sv
// bp_cache: direct-mapped valid/tag/2-bit store, two async read ports, one sync write
module bp_cache #(
  parameter int LINES = 128,
  parameter int IW    = 7,
  parameter int TW    = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] idx_g,
  output logic          vld_g,
  output logic [TW-1:0] tag_g,
  output logic [1:0]    dat_g,
  input  logic [IW-1:0] idx_c,
  output logic          vld_c,
  output logic [TW-1:0] tag_c,
  output logic [1:0]    dat_c,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_tag,
  input  logic [1:0]    wr_dat
);
  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [1:0]       dats [LINES];
  assign vld_g = valid[idx_g];
  assign tag_g = tags[idx_g];
  assign dat_g = dats[idx_g];
  assign vld_c = valid[idx_c];
  assign tag_c = tags[idx_c];
  assign dat_c = dats[idx_c];
  always_ff @(posedge clk or negedge rst)
    if (!rst) valid <= '0;
    else if (wr_en) valid[idx_c] <= 1'b1;
  // tag/counter storage carries no reset so it can map onto LUTRAM
  always_ff @(posedge clk)
    if (wr_en && rst) begin
      tags[idx_c] <= wr_tag;
      dats[idx_c] <= wr_dat;
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tagged 2-bit-counter direction predictor with branch statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int LINES     = 128,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bp_enable,
  input  logic [PC_WIDTH-1:0]  pc_guess,
  input  logic                 is_br_guess,
  output logic                 guess_taken,
  input  logic [PC_WIDTH-1:0]  pc_check,
  input  logic                 is_br_check,
  input  logic                 br_taken_check,
  input  logic                 guess_taken_check,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(PC_WIDTH, LINES);
  logic [IW-1:0] idx_g, idx_c;
  logic [TW-1:0] tag_g, tag_c, rtag_g, rtag_c;
  logic          vld_g, vld_c, hit_g, hit_c;
  logic [1:0]    ctr_g, ctr_c, ctr_n;
  logic          unused_pc_bits;
  assign idx_g = pc_guess[IW+1:2];
  assign tag_g = pc_guess[PC_WIDTH-1:IW+2];
  assign idx_c = pc_check[IW+1:2];
  assign tag_c = pc_check[PC_WIDTH-1:IW+2];
  assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};
  bp_cache #(.LINES(LINES), .IW(IW), .TW(TW)) u_cache (
    .clk(clk), .rst(rst),
    .idx_g(idx_g), .vld_g(vld_g), .tag_g(rtag_g), .dat_g(ctr_g),
    .idx_c(idx_c), .vld_c(vld_c), .tag_c(rtag_c), .dat_c(ctr_c),
    .wr_en(is_br_check), .wr_tag(tag_c), .wr_dat(ctr_n)
  );
  always_comb begin
    hit_g       = vld_g && rtag_g == tag_g;
    hit_c       = vld_c && rtag_c == tag_c;
    guess_taken = bp_enable && is_br_guess && hit_g && ctr_g[1];
    ctr_n       = hit_c ? sat_update(ctr_t'(ctr_c), br_taken_check) : (br_taken_check ? WT : WNT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      br_count         <= '0;
      mispredict_count <= '0;
    end else if (is_br_check) begin
      br_count         <= br_count + CNT_WIDTH'(1);
      mispredict_count <= mispredict_count + CNT_WIDTH'(guess_taken_check != br_taken_check);
    end
endmodule
